// File: rtl/noc_out_vc_scheduler.sv
// Output-port scheduler for a NoC switch: per-VC downstream credit tracking,
// (input, VC) arbitration and a registered one-hot-VC output stage.

module noc_vc_credit_ctr #(
   parameter int DEPTH = 4,
   parameter int CW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          send,
   input  logic          ret,
   output logic [CW-1:0] cnt,
   output logic          ovf
);
   localparam logic [CW-1:0] FULL = CW'(DEPTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // A grant needs a non-zero count, so decrement never underflows.
   always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      if (send && !ret) begin
         cnt_d = cnt_q - CW'(1);
      end else if (ret && !send) begin
         if (cnt_q == FULL) ovf = 1'b1;
         else               cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= FULL;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

module noc_out_vc_scheduler #(
   parameter int NUM_IN      = 3,
   parameter int VC_W        = 2,
   parameter int A_W         = 16,
   parameter int D_W         = 32,
   parameter int DEPTH       = 4,
   parameter int FAIR_VC_ARB = 0,
   localparam int P_W = A_W + D_W + 1,
   localparam int CW  = (DEPTH > 1)  ? $clog2(DEPTH)  : 1,
   localparam int IW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int VW  = (VC_W > 1)   ? $clog2(VC_W)   : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_IN-1:0][VC_W-1:0]           req_v,
   input  logic [NUM_IN-1:0][VC_W-1:0][P_W-1:0]  req_d,
   output logic [NUM_IN-1:0][VC_W-1:0]           req_b,
   output logic [VC_W-1:0]                       o_v,
   output logic [P_W-1:0]                        o_d,
   input  logic [VC_W-1:0]                       credit_ret,
   output logic [VC_W-1:0][CW-1:0]               credits,
   output logic                                  err_ovf
);
   if (DEPTH < 2 || NUM_IN < 1 || VC_W < 1) begin : g_bad_param
      $error("noc_out_vc_scheduler: need DEPTH>=2, NUM_IN>=1, VC_W>=1");
   end

   logic [NUM_IN-1:0][VC_W-1:0] elig;
   logic [VC_W-1:0]             vc_has;
   logic [VC_W-1:0]             send;
   logic [VC_W-1:0]             ovf;

   logic                  gnt_any, in_found;
   logic [VW-1:0]         gnt_vc;
   logic [IW-1:0]         gnt_in;
   int                    vc_idx, in_idx;

   logic [VC_W-1:0][IW-1:0] in_ptr_q, in_ptr_d;
   logic [VW-1:0]           vc_ptr_q, vc_ptr_d;
   logic [VC_W-1:0]         o_v_q, o_v_d;
   logic [P_W-1:0]          o_d_q, o_d_d;
   logic                    err_ovf_q, err_ovf_d;

   for (genvar v = 0; v < VC_W; v++) begin : g_vc
      noc_vc_credit_ctr #(.DEPTH(DEPTH), .CW(CW)) u_ctr (
         .clk  (clk),
         .rst  (rst),
         .send (send[v]),
         .ret  (credit_ret[v]),
         .cnt  (credits[v]),
         .ovf  (ovf[v])
      );
   end

   // Eligibility uses the registered counters, so a credit spent this cycle
   // is already reflected next cycle.
   always_comb begin
      vc_has = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         for (int v = 0; v < VC_W; v++) begin
            elig[i][v] = req_v[i][v] && (credits[v] != '0);
            vc_has[v]  = vc_has[v] | elig[i][v];
         end
      end
   end

   always_comb begin
      gnt_any  = 1'b0;
      gnt_vc   = '0;
      gnt_in   = '0;
      in_found = 1'b0;
      vc_idx   = 0;
      in_idx   = 0;
      for (int k = 0; k < VC_W; k++) begin
         if (FAIR_VC_ARB != 0) begin
            vc_idx = int'(vc_ptr_q) + k;
            if (vc_idx >= VC_W) vc_idx = vc_idx - VC_W;
         end else begin
            vc_idx = VC_W - 1 - k;
         end
         if (!gnt_any && vc_has[VW'(vc_idx)]) begin
            gnt_any = 1'b1;
            gnt_vc  = VW'(vc_idx);
         end
      end
      for (int k = 0; k < NUM_IN; k++) begin
         in_idx = int'(in_ptr_q[gnt_vc]) + k;
         if (in_idx >= NUM_IN) in_idx = in_idx - NUM_IN;
         if (gnt_any && !in_found && elig[IW'(in_idx)][gnt_vc]) begin
            in_found = 1'b1;
            gnt_in   = IW'(in_idx);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         for (int v = 0; v < VC_W; v++) begin
            req_b[i][v] = !(gnt_any && gnt_in == IW'(i) && gnt_vc == VW'(v));
         end
      end
      for (int v = 0; v < VC_W; v++) begin
         send[v] = gnt_any && gnt_vc == VW'(v);
      end
   end

   always_comb begin
      in_ptr_d  = in_ptr_q;
      vc_ptr_d  = vc_ptr_q;
      o_v_d     = '0;
      o_d_d     = o_d_q;
      err_ovf_d = err_ovf_q | (|ovf);
      if (gnt_any) begin
         in_ptr_d[gnt_vc] = (gnt_in == IW'(NUM_IN - 1)) ? '0 : gnt_in + IW'(1);
         if (FAIR_VC_ARB != 0) begin
            vc_ptr_d = (gnt_vc == VW'(VC_W - 1)) ? '0 : gnt_vc + VW'(1);
         end
         o_v_d[gnt_vc] = 1'b1;
         o_d_d         = req_d[gnt_in][gnt_vc];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ptr_q  <= '0;
         vc_ptr_q  <= '0;
         o_v_q     <= '0;
         o_d_q     <= '0;
         err_ovf_q <= 1'b0;
      end else begin
         in_ptr_q  <= in_ptr_d;
         vc_ptr_q  <= vc_ptr_d;
         o_v_q     <= o_v_d;
         o_d_q     <= o_d_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   assign o_v     = o_v_q;
   assign o_d     = o_d_q;
   assign err_ovf = err_ovf_q;
endmodule
